// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between the producers/fifo and the round-robin push arbiter.
interface fifo_push_arbiter_if #(
  parameter int unsigned nrOfRequesters = 4,
  parameter int unsigned bitWidth       = 32
);
  localparam int unsigned IdW = (nrOfRequesters > 1) ? $clog2(nrOfRequesters) : 1;

  logic [nrOfRequesters-1:0]          reqValid;
  logic [nrOfRequesters*bitWidth-1:0] reqData;
  logic [nrOfRequesters-1:0]          reqReady;
  logic                               fifoFull;
  logic                               fifoPush;
  logic [bitWidth-1:0]                fifoPushData;
  logic [IdW-1:0]                     grantId;
  logic                               busy;

  // Producers and fifo side
  modport master (
    output reqValid, reqData, fifoFull,
    input  reqReady, fifoPush, fifoPushData, grantId, busy
  );

  // Arbiter side
  modport slave (
    input  reqValid, reqData, fifoFull,
    output reqReady, fifoPush, fifoPushData, grantId, busy
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one fifo push port among several producers,
// with bursts of up to maxBurst beats per grant and full-flag backpressure.
module fifo_push_arbiter #(
  parameter int unsigned nrOfRequesters = 4,
  parameter int unsigned bitWidth       = 32,
  parameter int unsigned maxBurst       = 4
) (
  input  logic               clock,
  input  logic               reset,
  fifo_push_arbiter_if.slave bus
);
  localparam int unsigned IdW  = (nrOfRequesters > 1) ? $clog2(nrOfRequesters) : 1;
  localparam int unsigned CntW = $clog2(maxBurst) + 1;
  localparam logic [IdW-1:0]  LastId   = IdW'(nrOfRequesters - 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(maxBurst - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      grant_id_q, grant_id_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;

  logic [IdW-1:0]            winner_c;
  logic                      any_valid_c;
  logic                      sel_valid_c;
  logic [bitWidth-1:0]       sel_data_c;
  logic [nrOfRequesters-1:0] req_ready_c;
  logic                      push_c;
  logic [bitWidth-1:0]       push_data_c;

  // Round-robin search starting just after the last grantee
  always_comb begin
    logic [IdW-1:0] cand;
    cand        = '0;
    winner_c    = grant_id_q;
    any_valid_c = 1'b0;
    for (int unsigned k = 1; k <= nrOfRequesters; k++) begin
      cand = IdW'((32'(grant_id_q) + k) % nrOfRequesters);
      if (!any_valid_c && bus.reqValid[cand]) begin
        any_valid_c = 1'b1;
        winner_c    = cand;
      end
    end
  end

  // Valid and data of the currently granted requester
  always_comb begin
    sel_valid_c = bus.reqValid[grant_id_q];
    sel_data_c  = '0;
    for (int unsigned i = 0; i < nrOfRequesters; i++) begin
      if (grant_id_q == IdW'(i)) begin
        sel_data_c = bus.reqData[i*bitWidth +: bitWidth];
      end
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    req_ready_c = '0;
    push_c      = 1'b0;
    push_data_c = '0;
    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          grant_id_d = winner_c;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        req_ready_c[grant_id_q] = ~bus.fifoFull;
        push_c                  = sel_valid_c & ~bus.fifoFull;
        push_data_c             = sel_data_c;
        if (!sel_valid_c) begin
          state_d = IDLE;
        end else if (!bus.fifoFull) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (beat_cnt_q == LastBeat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and beat counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_id_q <= LastId;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.reqReady     = req_ready_c;
  assign bus.fifoPush     = push_c;
  assign bus.fifoPushData = push_data_c;
  assign bus.grantId      = grant_id_q;
  assign bus.busy         = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with producer and fifo models.
module tb_fifo_push_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  localparam int unsigned B = 4;

  logic clock = 1'b0;
  logic reset;

  fifo_push_arbiter_if #(.nrOfRequesters(N), .bitWidth(W)) bus ();

  fifo_push_arbiter #(.nrOfRequesters(N), .bitWidth(W), .maxBurst(B)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int errors;
  int checks;
  int cyc;
  int fifo_depth;
  logic pop_en;
  int req_left [N];
  logic [W-1:0] req_next [N];
  logic [W-1:0] fifo_q   [$];
  logic [W-1:0] push_log [$];
  logic [W-1:0] pop_log  [$];
  int grant_log [$];
  int push_cyc  [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      bus.reqValid[i]         = (req_left[i] > 0);
      bus.reqData[i*W +: W]   = req_next[i];
    end
    bus.fifoFull = (fifo_q.size() >= fifo_depth);
  endtask

  task automatic clear_logs();
    push_log.delete();
    pop_log.delete();
    grant_log.delete();
    push_cyc.delete();
    cyc = 0;
  endtask

  // One clock: sample handshake at negedge, update models after posedge
  task automatic cycle();
    logic         do_push;
    logic [W-1:0] pdata;
    logic [N-1:0] acc;
    @(negedge clock);
    cyc++;
    do_push = bus.fifoPush;
    pdata   = bus.fifoPushData;
    acc     = bus.reqValid & bus.reqReady;
    if (do_push || (|acc)) check_eq("push_eq_accept", 64'(do_push), 64'(|acc));
    if (do_push) begin
      check_eq("push_not_full", 64'(bus.fifoFull), 64'd0);
      push_log.push_back(pdata);
      grant_log.push_back(int'(bus.grantId));
      push_cyc.push_back(cyc);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (acc[i]) begin
        req_next[i] = req_next[i] + 32'd1;
        req_left[i] = req_left[i] - 1;
      end
    end
    if (pop_en && fifo_q.size() > 0) pop_log.push_back(fifo_q.pop_front());
    if (do_push) fifo_q.push_back(pdata);
    drive();
  endtask

  task automatic run_pushes(input int n, input string tag);
    for (int b = 0; b < 300 && push_log.size() < n; b++) cycle();
    check_eq(tag, 64'(push_log.size()), 64'(n));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      req_left[i] = 0;
      req_next[i] = '0;
    end
    pop_en     = 1'b0;
    fifo_depth = 1000;
    fifo_q.delete();
    drive();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_logs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    int n;
    errors = 0;
    checks = 0;
    apply_reset();

    // Reset values
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_grant", 64'(bus.grantId), 64'd3);
    check_eq("rst_push", 64'(bus.fifoPush), 64'd0);
    check_eq("rst_ready", 64'(bus.reqReady), 64'd0);
    check_eq("rst_data", 64'(bus.fifoPushData), 64'd0);

    // Single requester: two bursts of 4 with one idle bubble
    req_left[0] = 8;
    req_next[0] = 32'd1;
    drive();
    run_pushes(8, "t1_count");
    for (int k = 0; k < 8 && k < push_log.size(); k++)
      check_eq("t1_data", 64'(push_log[k]), 64'(k + 1));
    check_eq("t1_grant", 64'(grant_log[0]), 64'd0);
    check_eq("t1_burst1_back2back", 64'(push_cyc[3] - push_cyc[0]), 64'd3);
    check_eq("t1_bubble", 64'(push_cyc[4] - push_cyc[3]), 64'd2);
    check_eq("t1_burst2_back2back", 64'(push_cyc[7] - push_cyc[4]), 64'd3);

    // Round robin with all requesters valid: 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < int'(N); i++) begin
      req_left[i] = (i == 0) ? 8 : 4;
      req_next[i] = 32'(32'h100 * i);
    end
    drive();
    run_pushes(20, "t2_count");
    for (int k = 0; k < 20 && k < push_log.size(); k++) begin
      r = (k / 4) % 4;
      n = (k / 4 == 4) ? 4 + k % 4 : k % 4;
      check_eq("t2_data", 64'(push_log[k]), 64'(32'h100 * r + n));
      check_eq("t2_grant", 64'(grant_log[k]), 64'(r));
    end

    // Early release of requester 2, then requester 3
    apply_reset();
    req_left[2] = 2; req_next[2] = 32'h20;
    req_left[3] = 4; req_next[3] = 32'h30;
    drive();
    run_pushes(6, "t3_count");
    begin
      logic [W-1:0] exp_d [6] = '{32'h20, 32'h21, 32'h30, 32'h31, 32'h32, 32'h33};
      int           exp_g [6] = '{2, 2, 3, 3, 3, 3};
      for (int k = 0; k < 6 && k < push_log.size(); k++) begin
        check_eq("t3_data", 64'(push_log[k]), 64'(exp_d[k]));
        check_eq("t3_grant", 64'(grant_log[k]), 64'(exp_g[k]));
      end
    end
    check_eq("t3_release_gap", 64'(push_cyc[2] - push_cyc[1]), 64'd3);

    // Backpressure on a 16-entry fifo fed by requester 1
    apply_reset();
    fifo_depth  = 16;
    req_left[1] = 20;
    req_next[1] = 32'h1000;
    drive();
    run_pushes(16, "t4_fill");
    repeat (3) cycle();
    check_eq("t4_full", 64'(bus.fifoFull), 64'd1);
    check_eq("t4_ready_low", 64'(bus.reqReady), 64'd0);
    check_eq("t4_push_low", 64'(bus.fifoPush), 64'd0);
    check_eq("t4_busy_stall", 64'(bus.busy), 64'd1);
    check_eq("t4_no_push_stall", 64'(push_log.size()), 64'd16);
    pop_en = 1'b1;
    cycle();
    pop_en = 1'b0;
    repeat (3) cycle();
    check_eq("t4_one_push", 64'(push_log.size()), 64'd17);
    check_eq("t4_one_pop", 64'(pop_log.size()), 64'd1);
    pop_en     = 1'b1;
    fifo_depth = 1000;
    drive();
    run_pushes(20, "t4_all_pushed");
    check_eq("t4_rest_of_burst", 64'(push_cyc[19] - push_cyc[17]), 64'd2);
    for (int b = 0; b < 100 && pop_log.size() < 20; b++) cycle();
    check_eq("t4_pop_count", 64'(pop_log.size()), 64'd20);
    for (int k = 0; k < 20 && k < pop_log.size(); k++)
      check_eq("t4_pop_data", 64'(pop_log[k]), 64'(32'h1000 + k));

    // Fairness: requester 3 arrives during requester 0's burst
    apply_reset();
    req_left[0] = 100;
    req_next[0] = 32'h0;
    drive();
    run_pushes(2, "t5_first");
    req_left[3] = 4;
    req_next[3] = 32'h300;
    drive();
    run_pushes(12, "t5_count");
    for (int k = 0; k < 12 && k < grant_log.size(); k++)
      check_eq("t5_grant", 64'(grant_log[k]), 64'((k / 4 == 1) ? 3 : 0));

    // Asynchronous reset in the middle of a burst
    apply_reset();
    req_left[1] = 10;
    req_next[1] = 32'h500;
    drive();
    run_pushes(1, "t6_first");
    @(negedge clock);
    check_eq("t6_second_beat", 64'(bus.fifoPush), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("t6_push_async", 64'(bus.fifoPush), 64'd0);
    check_eq("t6_ready_async", 64'(bus.reqReady), 64'd0);
    check_eq("t6_busy_async", 64'(bus.busy), 64'd0);
    check_eq("t6_data_async", 64'(bus.fifoPushData), 64'd0);
    check_eq("t6_grant_async", 64'(bus.grantId), 64'd3);
    @(posedge clock);
    #1;
    clear_logs();
    req_left[0] = 2;
    req_next[0] = 32'h700;
    drive();
    @(negedge clock);
    reset = 1'b1;
    run_pushes(3, "t6_after");
    check_eq("t6_first_grant", 64'(grant_log[0]), 64'd0);
    check_eq("t6_first_data", 64'(push_log[0]), 64'h700);
    check_eq("t6_inflight_kept", 64'(push_log[2]), 64'h501);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that lets nrOfRequesters producers share the single push port of one fifo instance. It grants one requester at a time and forwards that requester's data onto the fifo push interface. A grant covers up to maxBurst beats. The block honours fifo backpressure (full) so that no push is ever issued into a full fifo. It sits directly in front of the fifo; the pop side is untouched.

Parameters:
nrOfRequesters, 4, number of producers sharing the fifo (2..16)
bitWidth, 32, data width; must equal the fifo bitWidth
maxBurst, 4, maximum beats transferred per grant (1..16)

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
reqValid  input  nrOfRequesters  per-requester data-valid
reqData  input  nrOfRequesters*bitWidth  per-requester data; requester i occupies bits [i*bitWidth +: bitWidth]
reqReady  output  nrOfRequesters  per-requester accept strobe; a beat transfers when reqValid[i] & reqReady[i]
fifoFull  input  1  full flag from the fifo
fifoPush  output  1  push strobe to the fifo
fifoPushData  output  bitWidth  push data to the fifo
grantId  output  clog2(nrOfRequesters)  index of the current or last granted requester
busy  output  1  high while in GRANT state

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, beatCount = 0, grantId = nrOfRequesters-1 (so requester 0 has first priority).
  - reqReady = 0, fifoPush = 0, fifoPushData = 0, busy = 0.
  - Reset asserted mid-burst aborts the burst immediately; the in-flight beat is not pushed.
- State machine: two states, IDLE and GRANT.
- IDLE:
  - All reqReady = 0; fifoPush = 0.
  - If any reqValid is high, pick the first valid requester scanning grantId+1, grantId+2, … with wrap modulo nrOfRequesters.
  - Register the winner into grantId, clear beatCount, go to GRANT.
  - Arbitration latency is exactly 1 cycle.
  - The previous grantee is considered last, so it can win again only if no other requester is valid.
- GRANT (combinational outputs from registered grantId):
  - reqReady[grantId] = ~fifoFull; all other reqReady bits = 0.
  - fifoPush = reqValid[grantId] & ~fifoFull.
  - fifoPushData = reqData slice of grantId, driven every cycle in GRANT; it is 0 in IDLE.
  - On a transfer, beatCount increments. If beatCount was maxBurst-1, go to IDLE (burst complete).
  - If reqValid[grantId] is low in a cycle, go to IDLE (early release). This applies even if fifoFull is high.
  - If fifoFull is high and reqValid[grantId] is high: stall. Hold the state and hold beatCount; fifoPush stays 0.
- Throughput:
  - Sustained maxBurst beats per grant, then one IDLE bubble, i.e. maxBurst/(maxBurst+1) utilisation with continuous requests.
  - No back-to-back grants without an IDLE cycle.
- Boundary and usage rules:
  - A non-granted requester holding valid waits indefinitely; starvation is bounded to (nrOfRequesters-1)*(maxBurst+1) non-full cycles.
  - A requester deasserting valid while not granted is legal.
  - grantId retains its value in IDLE; it is the round-robin pointer.
  - beatCount width is clog2(maxBurst)+1. With maxBurst = 1, every grant is a single beat.
  - Requesters must hold reqData stable while reqValid is high and not accepted.

Test Plan:
- Single requester, no backpressure: reset low for 2 cycles, then reqValid = 4'b0001 with data 1,2,3,… → grantId 0, fifoPush high for 4 consecutive cycles pushing 1..4, one IDLE cycle, next burst pushes 5..8.
- Round-robin order: reqValid = 4'b1111 held continuously, each requester sending a distinct base value (0x100·i+n) → grants in order 0,1,2,3,0; each grant pushes 4 beats; the fifo pop sequence matches.
- Early release: requester 2 valid for 2 beats then drops while requester 3 is valid → 2 pushes from requester 2, IDLE, then grantId = 3.
- Backpressure: a 16-entry, 32-bit fifo filled via requester 1, with no pops → fifoFull = 1, reqReady = 0, fifoPush = 0, beatCount frozen. Pop once → exactly one push occurs, and no data is lost or duplicated over 20 beats.
- Fairness: requester 0 valid continuously, requester 3 asserts valid during requester 0's burst → requester 3 is granted at the next IDLE, before requester 0 is re-granted.
- Reset mid-burst: assert reset on the 2nd beat of a grant to requester 1 → outputs zero in the same cycle (asynchronously). After release, first grant goes to the lowest valid index starting from 0.
